// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared codec serial-audio constants and receive FSM states
package codec_pkg;

    localparam int SLOT_BITS = 32;
    localparam int I2S_DELAY = 1;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        SHIFT,
        COMMIT,
        WAIT
    } i2s_rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage synchronizer with edge strobes on the synced level
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2s_rx_capture.sv
// rtl/i2s_rx_capture.sv - oversampled I2S receiver producing left/right sample pairs
module i2s_rx_capture
    import codec_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2s_bclk,
    input  logic             i2s_lr,
    input  logic             i2s_sdata,
    output logic [WIDTH-1:0] sample_l,
    output logic [WIDTH-1:0] sample_r,
    output logic             new_sample,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                   bclk_rise;
    logic                   bclk_level_unused;
    logic                   bclk_fall_unused;
    logic                   lr_level;
    logic                   lr_rise;
    logic                   lr_fall;
    logic                   lr_edge;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   sdata_s;
    logic [WIDTH-1:0]       word;

    i2s_rx_state_t          state;
    logic                   chan;
    logic                   left_ok;
    logic [WIDTH-1:0]       shreg;
    logic [WIDTH-1:0]       hold_l;
    logic [CNT_W-1:0]       bit_cnt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i2s_bclk),
        .level (bclk_level_unused),
        .rise  (bclk_rise),
        .fall  (bclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_lr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i2s_lr),
        .level (lr_level),
        .rise  (lr_rise),
        .fall  (lr_fall)
    );

    // sdata has no edge flop so it lines up with the bclk strobe cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdata_sync <= '0;
        end else begin
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
        end
    end

    assign sdata_s = sdata_sync[SYNC_STAGES-1];
    assign lr_edge = lr_rise | lr_fall;
    assign word    = {shreg[WIDTH-2:0], sdata_s};

    // Commit work is done on the edge entering COMMIT so new_sample is high during COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            chan       <= 1'b0;
            left_ok    <= 1'b0;
            shreg      <= '0;
            hold_l     <= '0;
            bit_cnt    <= '0;
            sample_l   <= '0;
            sample_r   <= '0;
            new_sample <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (lr_fall) begin
                        chan  <= 1'b0;
                        state <= SKIP;
                    end
                end
                SKIP, SHIFT: begin
                    if (lr_edge) begin
                        frame_err <= 1'b1;
                        left_ok   <= 1'b0;
                        chan      <= lr_level;
                        bit_cnt   <= '0;
                        state     <= SKIP;
                    end else if (bclk_rise) begin
                        if (state == SKIP) begin
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end else begin
                            shreg <= word;
                            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                                state <= COMMIT;
                                if (!chan) begin
                                    hold_l  <= word;
                                    left_ok <= 1'b1;
                                end else if (left_ok) begin
                                    sample_l   <= hold_l;
                                    sample_r   <= word;
                                    new_sample <= 1'b1;
                                    left_ok    <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                COMMIT, WAIT: begin
                    if (lr_edge) begin
                        chan    <= lr_level;
                        bit_cnt <= '0;
                        state   <= SKIP;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb/tb_i2s_rx_capture.sv - directed self-checking bench for i2s_rx_capture
module tb_i2s_rx_capture;

    logic        clk;
    logic        reset;
    logic        i2s_bclk;
    logic        i2s_lr;
    logic        i2s_sdata;
    logic [23:0] sample_l24;
    logic [23:0] sample_r24;
    logic        new_sample24;
    logic        frame_err24;
    logic [15:0] sample_l16;
    logic [15:0] sample_r16;
    logic        new_sample16;
    logic        frame_err16;

    int          n_tests;
    int          n_fail;
    int          np24;
    int          np16;
    int          nfe24;
    logic [23:0] q_l[$];
    logic [23:0] q_r[$];
    logic [15:0] last_l16;
    logic [15:0] last_r16;
    longint      t_pulse;
    longint      t_last;

    i2s_rx_capture #(.WIDTH(24), .SYNC_STAGES(2)) dut24 (
        .clk        (clk),
        .reset      (reset),
        .i2s_bclk   (i2s_bclk),
        .i2s_lr     (i2s_lr),
        .i2s_sdata  (i2s_sdata),
        .sample_l   (sample_l24),
        .sample_r   (sample_r24),
        .new_sample (new_sample24),
        .frame_err  (frame_err24)
    );

    i2s_rx_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk        (clk),
        .reset      (reset),
        .i2s_bclk   (i2s_bclk),
        .i2s_lr     (i2s_lr),
        .i2s_sdata  (i2s_sdata),
        .sample_l   (sample_l16),
        .sample_r   (sample_r16),
        .new_sample (new_sample16),
        .frame_err  (frame_err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_sample24) begin
            np24++;
            q_l.push_back(sample_l24);
            q_r.push_back(sample_r24);
            t_pulse = $time;
        end
        if (new_sample16) begin
            np16++;
            last_l16 = sample_l16;
            last_r16 = sample_r16;
        end
        if (frame_err24) nfe24++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot bit k: k=0 is the delay bit, k=1..24 carry w MSB-first, the rest are padding
    task automatic send_slot(input logic lr_v, input logic [23:0] w, input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            i2s_bclk  = 1'b0;
            i2s_lr    = lr_v;
            i2s_sdata = (k >= 1 && k <= 24) ? w[24-k] : 1'b1;
            #160;
            i2s_bclk = 1'b1;
            if (k == 24 && lr_v) t_last = $time;
            #160;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 0, 31);
        send_slot(1'b1, r, 0, 31);
    endtask

    logic [23:0] tri_l[3];
    logic [23:0] tri_r[3];
    int          base;
    int          base16;
    int          base_fe;
    longint      dt;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lr    = 1'b1;
        i2s_sdata = 1'b0;
        tri_l = '{24'h123456, 24'h000000, 24'h000001};
        tri_r = '{24'hABCDEF, 24'hFFFFFF, 24'h800000};

        #23;
        check("rst_sample_l", {8'h0, sample_l24}, 32'h0);
        check("rst_sample_r", {8'h0, sample_r24}, 32'h0);
        check("rst_new_sample", {31'h0, new_sample24}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err24}, 32'h0);
        reset = 1'b0;
        #40;

        // Nominal frame
        base = np24; base16 = np16; base_fe = nfe24;
        send_frame(24'h7FFFFF, 24'h800001);
        #200;
        check("nom_pulses", np24 - base, 1);
        check("nom_l", {8'h0, q_l[base]}, 32'h7FFFFF);
        check("nom_r", {8'h0, q_r[base]}, 32'h800001);
        dt = t_pulse - t_last;
        check("nom_latency", {31'h0, (dt >= 20 && dt <= 60)}, 32'h1);
        check("nom_frame_err", nfe24 - base_fe, 0);
        check("nom16_pulses", np16 - base16, 1);
        check("nom16_l", {16'h0, last_l16}, 32'h7FFF);
        check("nom16_r", {16'h0, last_r16}, 32'h8000);

        // Back-to-back frames, padding bits driven high
        base = np24;
        for (int i = 0; i < 3; i++) send_frame(tri_l[i], tri_r[i]);
        #200;
        check("b2b_pulses", np24 - base, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_l%0d", i), {8'h0, q_l[base+i]}, {8'h0, tri_l[i]});
            check($sformatf("b2b_r%0d", i), {8'h0, q_r[base+i]}, {8'h0, tri_r[i]});
        end

        // Reset at bit 12 of the right slot, then restart mid-right-slot
        send_slot(1'b0, 24'h111111, 0, 31);
        send_slot(1'b1, 24'h222222, 0, 12);
        reset = 1'b1;
        #7;
        check("midrst_l", {8'h0, sample_l24}, 32'h0);
        check("midrst_r", {8'h0, sample_r24}, 32'h0);
        check("midrst_ns", {31'h0, new_sample24}, 32'h0);
        check("midrst16_l", {16'h0, sample_l16}, 32'h0);
        #20;
        reset = 1'b0;
        base = np24;
        send_slot(1'b1, 24'h222222, 13, 31);
        #200;
        check("midrst_no_pulse", np24 - base, 0);
        send_frame(24'h13579B, 24'h2468AC);
        #200;
        check("midrst_resume_pulses", np24 - base, 1);
        check("midrst_resume_l", {8'h0, q_l[base]}, 32'h13579B);
        check("midrst_resume_r", {8'h0, q_r[base]}, 32'h2468AC);

        // lr toggles after 10 left bits
        base = np24; base_fe = nfe24;
        send_slot(1'b0, 24'h333333, 0, 10);
        send_slot(1'b1, 24'h444444, 0, 31);
        #200;
        check("abort_frame_err", nfe24 - base_fe, 1);
        check("abort_no_pulse", np24 - base, 0);
        send_frame(24'h5A5A5A, 24'hA5A5A5);
        #200;
        check("abort_resume_pulses", np24 - base, 1);
        check("abort_resume_l", {8'h0, q_l[base]}, 32'h5A5A5A);
        check("abort_resume_r", {8'h0, q_r[base]}, 32'hA5A5A5);
        check("abort_resume_fe", nfe24 - base_fe, 1);

        // 16-bit instance takes the upper 16 bits of each slot
        base16 = np16;
        send_frame(24'hBEEF00, 24'h1234FF);
        #200;
        check("w16_pulses", np16 - base16, 1);
        check("w16_l", {16'h0, last_l16}, 32'hBEEF);
        check("w16_r", {16'h0, last_r16}, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
